// File: rtl/case_cmd_if.sv
// Command-in / issue-out handshake bundle for the case-mux command sequencer.
// The slave side buffers commands and issues sel/data beats.
interface case_cmd_if #(
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_sel;
  logic [7:0]       cmd_data;
  logic [CNT_W-1:0] cmd_rpt;
  logic [2:0]       sel;
  logic [7:0]       data;
  logic             issue_valid;
  logic             issue_ready;

  modport master (
    output cmd_valid, cmd_sel, cmd_data, cmd_rpt, issue_ready,
    input  cmd_ready, sel, data, issue_valid
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_data, cmd_rpt, issue_ready,
    output cmd_ready, sel, data, issue_valid
  );
endinterface

// File: rtl/case_cmd_sequencer.sv
// Command FIFO plus repeat-issue FSM feeding the 3-bit-select case mux.
// Each command drives sel/data for (rpt+1) accepted beats.
module case_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  case_cmd_if.slave                bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 11 + CNT_W;

  typedef enum logic {IDLE, ISSUE} state_e;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       sel_q;
  logic [7:0]       data_q;
  logic             vld_q;
  state_e           state_q;

  logic             push, pop, accept, last;
  logic [EW-1:0]    head;

  always_comb begin
    bus.cmd_ready = (level_q != LW'(DEPTH)) && !flush && rst_n;
    push    = bus.cmd_valid && bus.cmd_ready;
    accept  = (state_q == ISSUE) && bus.issue_ready;
    last    = (cnt_q == '0);
    // A pop refills the issue regs at the edge the last beat retires
    pop     = (level_q != '0) && !flush &&
              ((state_q == IDLE) || (accept && last));
    head    = mem_q[rd_q];
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {bus.cmd_sel, bus.cmd_data, bus.cmd_rpt};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      state_q <= IDLE;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      level_q <= level_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            {sel_q, data_q, cnt_q} <= head;
            vld_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            if (!last) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else if (pop) begin
              {sel_q, data_q, cnt_q} <= head;
            end else begin
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel         = sel_q;
  assign bus.data        = data_q;
  assign bus.issue_valid = vld_q;
  assign level           = level_q;
  assign busy            = (state_q == ISSUE) || (level_q != '0);
endmodule

// File: tb/tb_case_cmd_sequencer.sv
// Scoreboard bench for case_cmd_sequencer: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_case_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] level;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_beats = 0;

  logic [10:0] exp_q[$];
  logic        stall = 1'b0;
  logic [10:0] held  = '0;

  case_cmd_if #(.CNT_W(4)) bus ();

  case_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .level (level),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.issue_valid) begin
      if (stall) chk("stable_sel_data", {21'd0, bus.sel, bus.data}, {21'd0, held});
      if (bus.issue_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", {bus.sel, bus.data});
        end else begin
          chk("beat", {21'd0, bus.sel, bus.data}, {21'd0, exp_q.pop_front()});
        end
        stall = 1'b0;
      end else begin
        stall = 1'b1;
        held  = {bus.sel, bus.data};
      end
    end else begin
      stall = 1'b0;
    end
  end

  task automatic push(input logic [2:0] s, input logic [7:0] d,
                      input logic [3:0] r);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = s;
    bus.cmd_data  = d;
    bus.cmd_rpt   = r;
    @(negedge clk);
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int i = 0; i <= int'(r); i++) exp_q.push_back({s, d});
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((bus.issue_valid || busy) && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", {30'd0, bus.issue_valid, busy}, 32'd0);
  endtask

  task automatic wait_valid();
    int t = 0;
    @(negedge clk);
    while (!bus.issue_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("valid_timeout", {31'd0, bus.issue_valid}, 32'd1);
  endtask

  int b0;

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_sel     = '0;
    bus.cmd_data    = '0;
    bus.cmd_rpt     = '0;
    bus.issue_ready = 1'b0;

    // 1: reset
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, bus.issue_valid}, 32'd0);
    chk("post_rst_level", {29'd0, level}, 32'd0);
    chk("post_rst_sel_data", {21'd0, bus.sel, bus.data}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // 2: single beat, latency 2
    @(posedge clk);
    #1 bus.issue_ready = 1'b1;
    push(3'b011, 8'h3C, 4'd0);
    @(negedge clk);
    chk("lat_edge1_valid", {31'd0, bus.issue_valid}, 32'd0);
    @(negedge clk);
    chk("lat_edge2_valid", {31'd0, bus.issue_valid}, 32'd1);
    chk("lat_sel_data", {21'd0, bus.sel, bus.data}, {21'd0, 3'b011, 8'h3C});
    @(negedge clk);
    chk("single_drop_valid", {31'd0, bus.issue_valid}, 32'd0);
    chk("single_busy", {31'd0, busy}, 32'd0);

    // 3: repeat 2 with ready toggling
    @(posedge clk);
    #1 b0 = n_beats;
    push(3'b101, 8'h10, 4'd2);
    wait_valid();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 bus.issue_ready = ~bus.issue_ready;
    end
    bus.issue_ready = 1'b1;
    wait_idle();
    chk("rpt2_beats", n_beats - b0, 32'd3);

    // 4: fill FIFO while stalled, then drain back-to-back
    @(posedge clk);
    #1 bus.issue_ready = 1'b0;
    b0 = n_beats;
    push(3'b110, 8'h11, 4'd0);
    push(3'b111, 8'h22, 4'd0);
    push(3'b000, 8'h33, 4'd0);
    push(3'b001, 8'h44, 4'd0);
    push(3'b010, 8'h55, 4'd0);
    @(negedge clk);
    chk("full_level", {29'd0, level}, 32'd4);
    chk("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = 3'b100;
    bus.cmd_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("blocked_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_no_bubble", {31'd0, bus.issue_valid}, 32'd1);
    end
    @(negedge clk);
    chk("drain_done_valid", {31'd0, bus.issue_valid}, 32'd0);
    chk("drain_beats", n_beats - b0, 32'd5);

    // 5: flush with full FIFO and stalled issue
    @(posedge clk);
    #1 bus.issue_ready = 1'b0;
    push(3'b001, 8'hA1, 4'd0);
    push(3'b010, 8'hA2, 4'd1);
    push(3'b011, 8'hA3, 4'd0);
    push(3'b100, 8'hA4, 4'd0);
    push(3'b101, 8'hA5, 4'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = 3'b111;
    bus.cmd_data  = 8'hEE;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_level", {29'd0, level}, 32'd0);
    chk("flush_valid", {31'd0, bus.issue_valid}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_keep_sel_data", {21'd0, bus.sel, bus.data}, {21'd0, 3'b001, 8'hA1});
    @(posedge clk);
    #1 bus.issue_ready = 1'b1;
    b0 = n_beats;
    push(3'b100, 8'h5A, 4'd0);
    wait_idle();
    chk("post_flush_beats", n_beats - b0, 32'd1);

    // 6: reset mid-repeat
    @(posedge clk);
    #1 push(3'b010, 8'hAA, 4'd9);
    wait_valid();
    repeat (4) @(posedge clk);
    #1 bus.issue_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, bus.issue_valid}, 32'd0);
    chk("rst_mid_sel_data", {21'd0, bus.sel, bus.data}, 32'd0);
    chk("rst_mid_level", {29'd0, level}, 32'd0);
    chk("rst_mid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.issue_ready = 1'b1;
    b0 = n_beats;
    repeat (10) @(negedge clk);
    chk("rst_no_more_beats", n_beats - b0, 32'd0);
    chk("rst_idle_valid", {31'd0, bus.issue_valid}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
